// File: rtl/dcache_meta_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_meta_wb_pkg
// Purpose  : Shared constants and the entry type for the data-cache metadata
//            write buffer.
//            - c_DEPTH / c_IDX_W / c_WAY_W / c_TAG_W : default widths and depth
//            - meta_wb_entry_t                      : one buffered tag write
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
package dcache_meta_wb_pkg;

    localparam int unsigned c_DEPTH = 4;
    localparam int unsigned c_IDX_W = 6;
    localparam int unsigned c_WAY_W = 8;
    localparam int unsigned c_TAG_W = 20;

    typedef struct packed {
        logic [c_IDX_W-1:0] idx;
        logic [c_WAY_W-1:0] way_en;
        logic [c_TAG_W-1:0] tag;
    } meta_wb_entry_t;

endpackage : dcache_meta_wb_pkg
`default_nettype wire

// File: rtl/meta_wb_hazard_cmp.sv
`default_nettype none
// ============================================================================
// Module   : meta_wb_hazard_cmp
// Purpose  : Flags a tag-array read whose set index collides with any occupied
//            buffer entry or with the entry being accepted this cycle.
// Ports    : i_entry_idx  - flattened idx field of every buffer slot
//            i_occ        - one bit per slot, set when the slot holds a write
//            i_read_valid - tag-array read this cycle
//            i_read_idx   - set index of that read
//            i_enq_valid  - an entry is accepted this cycle
//            i_enq_idx    - set index of the accepted entry
//            o_hazard     - read collides with a pending or arriving write
// Macros   : only instantiated when META_WRITE_BUF_HAZARD_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module meta_wb_hazard_cmp
    import dcache_meta_wb_pkg::*;
#(
    parameter int unsigned DEPTH = c_DEPTH,
    parameter int unsigned IDX_W = c_IDX_W
) (
    input  logic [DEPTH*IDX_W-1:0] i_entry_idx,
    input  logic [DEPTH-1:0]       i_occ,
    input  logic                   i_read_valid,
    input  logic [IDX_W-1:0]       i_read_idx,
    input  logic                   i_enq_valid,
    input  logic [IDX_W-1:0]       i_enq_idx,
    output logic                   o_hazard
);

    logic [DEPTH-1:0] w_hit;
    logic             w_enq_hit;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign w_hit[gi] = i_occ[gi] & (i_entry_idx[gi*IDX_W +: IDX_W] == i_read_idx);
    end

    assign w_enq_hit = i_enq_valid & (i_enq_idx == i_read_idx);
    assign o_hazard  = i_read_valid & ((|w_hit) | w_enq_hit);

endmodule : meta_wb_hazard_cmp
`default_nettype wire

// File: rtl/dcache_meta_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dcache_meta_write_buffer
// Purpose  : Small FIFO of pending tag-array writes. Entries drain one per
//            cycle whenever no tag-array read is in progress; reads always win.
// Ports    : clock, reset (synchronous, active-high)
//            io_in_valid/io_in_ready   - enqueue handshake
//            io_in_bits_idx/way_en/tag - enqueue payload
//            io_read_valid/io_read_idx - tag-array read this cycle
//            io_read_hazard            - read set has a pending write
//            io_write_en/idx/way_en/tag- tag-array write strobe and payload
//            io_count                  - registered occupancy
// Macros   : META_WRITE_BUF_HAZARD_EN - enables the read-hazard comparators;
//            when undefined io_read_hazard is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_meta_write_buffer
    import dcache_meta_wb_pkg::*;
#(
    parameter int unsigned DEPTH = c_DEPTH,
    parameter int unsigned IDX_W = c_IDX_W,
    parameter int unsigned WAY_W = c_WAY_W,
    parameter int unsigned TAG_W = c_TAG_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_in_valid,
    output logic                       io_in_ready,
    input  logic [IDX_W-1:0]           io_in_bits_idx,
    input  logic [WAY_W-1:0]           io_in_bits_way_en,
    input  logic [TAG_W-1:0]           io_in_bits_tag,
    input  logic                       io_read_valid,
    input  logic [IDX_W-1:0]           io_read_idx,
    output logic                       io_read_hazard,
    output logic                       io_write_en,
    output logic [IDX_W-1:0]           io_write_idx,
    output logic [WAY_W-1:0]           io_write_way_en,
    output logic [TAG_W-1:0]           io_write_tag,
    output logic [$clog2(DEPTH):0]     io_count
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_DRAIN = 1'b1;

    logic [IDX_W-1:0]   r_idx [DEPTH];
    logic [WAY_W-1:0]   r_way [DEPTH];
    logic [TAG_W-1:0]   r_tag [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               w_in_ready;
    logic               w_enq;
    logic               w_deq;

    // Ready depends only on registered count, so there is no in-to-write path.
    assign w_in_ready = (r_count != c_CNT_W'(DEPTH));
    assign w_enq      = io_in_valid & w_in_ready;

    // Storage is deliberately not reset; occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_idx[r_tail] <= io_in_bits_idx;
            r_way[r_tail] <= io_in_bits_way_en;
            r_tag[r_tail] <= io_in_bits_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Reads stall the drain; reset also suppresses the strobe so an entry
    // discarded by reset is never written in that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_deq       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_enq) begin
                    w_state_nxt = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                w_deq = ~io_read_valid & ~reset;
                if (w_deq && !w_enq && (r_count == c_CNT_W'(1))) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    assign io_in_ready     = w_in_ready;
    assign io_write_en     = w_deq;
    assign io_write_idx    = w_deq ? r_idx[r_head] : '0;
    assign io_write_way_en = w_deq ? r_way[r_head] : '0;
    assign io_write_tag    = w_deq ? r_tag[r_head] : '0;
    assign io_count        = r_count;

`ifdef META_WRITE_BUF_HAZARD_EN
    logic [DEPTH-1:0]       w_occ;
    logic [DEPTH*IDX_W-1:0] w_idx_flat;

    // Slot i is occupied when its distance from head is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
        logic [c_PTR_W-1:0] w_off;
        assign w_off                         = c_PTR_W'(gi) - r_head;
        assign w_occ[gi]                     = ({1'b0, w_off} < r_count);
        assign w_idx_flat[gi*IDX_W +: IDX_W] = r_idx[gi];
    end

    meta_wb_hazard_cmp #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_hazard_cmp (
        .i_entry_idx  (w_idx_flat),
        .i_occ        (w_occ),
        .i_read_valid (io_read_valid),
        .i_read_idx   (io_read_idx),
        .i_enq_valid  (w_enq),
        .i_enq_idx    (io_in_bits_idx),
        .o_hazard     (io_read_hazard)
    );
`else
    logic w_unused_read_idx;
    assign w_unused_read_idx = ^io_read_idx;
    assign io_read_hazard    = 1'b0;
`endif

endmodule : dcache_meta_write_buffer
`default_nettype wire

// File: tb/tb_dcache_meta_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_meta_write_buffer
// Purpose  : Directed self-checking bench for dcache_meta_write_buffer.
//            Hazard expectations follow META_WRITE_BUF_HAZARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_meta_write_buffer;
    import dcache_meta_wb_pkg::*;

`ifdef META_WRITE_BUF_HAZARD_EN
    localparam logic c_HZ = 1'b1;
`else
    localparam logic c_HZ = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [5:0]  io_in_bits_idx;
    logic [7:0]  io_in_bits_way_en;
    logic [19:0] io_in_bits_tag;
    logic        io_read_valid;
    logic [5:0]  io_read_idx;
    logic        io_read_hazard;
    logic        io_write_en;
    logic [5:0]  io_write_idx;
    logic [7:0]  io_write_way_en;
    logic [19:0] io_write_tag;
    logic [2:0]  io_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    dcache_meta_write_buffer dut (
        .clock             (clock),
        .reset             (reset),
        .io_in_valid       (io_in_valid),
        .io_in_ready       (io_in_ready),
        .io_in_bits_idx    (io_in_bits_idx),
        .io_in_bits_way_en (io_in_bits_way_en),
        .io_in_bits_tag    (io_in_bits_tag),
        .io_read_valid     (io_read_valid),
        .io_read_idx       (io_read_idx),
        .io_read_hazard    (io_read_hazard),
        .io_write_en       (io_write_en),
        .io_write_idx      (io_write_idx),
        .io_write_way_en   (io_write_way_en),
        .io_write_tag      (io_write_tag),
        .io_count          (io_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_write(input string tag, input meta_wb_entry_t e);
        check({tag, "_en"},  32'(io_write_en),     32'd1);
        check({tag, "_idx"}, 32'(io_write_idx),    32'(e.idx));
        check({tag, "_way"}, 32'(io_write_way_en), 32'(e.way_en));
        check({tag, "_tag"}, 32'(io_write_tag),    32'(e.tag));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input logic v, input meta_wb_entry_t e, input logic rv, input logic [5:0] ridx);
        @(negedge clock);
        reset             = 1'b0;
        io_in_valid       = v;
        io_in_bits_idx    = e.idx;
        io_in_bits_way_en = e.way_en;
        io_in_bits_tag    = e.tag;
        io_read_valid     = rv;
        io_read_idx       = ridx;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        meta_wb_entry_t none, e0, a, b, c, d, h1, h2, h3, h4, f;
        meta_wb_entry_t q [4];
        none = '0;
        e0   = '{idx: 6'h05, way_en: 8'h04, tag: 20'hABCDE};
        q[0] = '{idx: 6'h0A, way_en: 8'h01, tag: 20'h11111};
        q[1] = '{idx: 6'h0B, way_en: 8'h02, tag: 20'h22222};
        q[2] = '{idx: 6'h0C, way_en: 8'h04, tag: 20'h33333};
        q[3] = '{idx: 6'h0D, way_en: 8'h08, tag: 20'h44444};
        a    = '{idx: 6'h21, way_en: 8'h10, tag: 20'h0A0A0};
        b    = '{idx: 6'h22, way_en: 8'h20, tag: 20'h0B0B0};
        c    = '{idx: 6'h23, way_en: 8'h40, tag: 20'h0C0C0};
        d    = '{idx: 6'h24, way_en: 8'h80, tag: 20'h0D0D0};
        h1   = '{idx: 6'h12, way_en: 8'h01, tag: 20'h12345};
        h2   = '{idx: 6'h20, way_en: 8'h02, tag: 20'h54321};
        h3   = '{idx: 6'h30, way_en: 8'h04, tag: 20'h33330};
        h4   = '{idx: 6'h31, way_en: 8'h08, tag: 20'h44440};
        f    = '{idx: 6'h3A, way_en: 8'h80, tag: 20'h0F00F};

        reset = 1'b1; io_in_valid = 1'b0; io_in_bits_idx = '0; io_in_bits_way_en = '0;
        io_in_bits_tag = '0; io_read_valid = 1'b0; io_read_idx = '0;
        repeat (2) @(posedge clock);

        // Reset state
        step(1'b0, none, 1'b0, 6'h00);
        check("rst_write_en", 32'(io_write_en),    32'd0);
        check("rst_hazard",   32'(io_read_hazard), 32'd0);
        check("rst_count",    32'(io_count),       32'd0);
        check("rst_in_ready", 32'(io_in_ready),    32'd1);

        // Single entry: written one cycle after enqueue
        step(1'b1, e0, 1'b0, 6'h00);
        check("single_no_passthru", 32'(io_write_en), 32'd0);
        step(1'b0, none, 1'b0, 6'h00);
        check("single_count", 32'(io_count), 32'd1);
        check_write("single", e0);
        step(1'b0, none, 1'b0, 6'h00);
        check("single_count_after", 32'(io_count),     32'd0);
        check("single_idle",        32'(io_write_en),  32'd0);
        check("payload_zero_idx",   32'(io_write_idx), 32'd0);
        check("payload_zero_tag",   32'(io_write_tag), 32'd0);

        // Fill while reads stall the drain
        for (int i = 0; i < 4; i++) begin
            step(1'b1, q[i], 1'b1, 6'h3F);
            check("fill_stalled", 32'(io_write_en), 32'd0);
        end
        step(1'b1, e0, 1'b1, 6'h3F);
        check("full_count",    32'(io_count),    32'd4);
        check("full_ready",    32'(io_in_ready), 32'd0);
        check("full_write_en", 32'(io_write_en), 32'd0);
        step(1'b0, none, 1'b1, 6'h3F);
        check("full_hold", 32'(io_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, none, 1'b0, 6'h00);
            check_write("drain_order", q[i]);
        end
        step(1'b0, none, 1'b0, 6'h00);
        check("drain_empty", 32'(io_count),    32'd0);
        check("drain_done",  32'(io_write_en), 32'd0);

        // Simultaneous enqueue/dequeue at count=2 with tail wrapping 3->0
        step(1'b1, a, 1'b1, 6'h3F);
        step(1'b1, b, 1'b1, 6'h3F);
        step(1'b0, none, 1'b1, 6'h3F);
        check("sim_count_pre", 32'(io_count), 32'd2);
        step(1'b1, c, 1'b0, 6'h00);
        check_write("sim_a", a);
        step(1'b1, d, 1'b0, 6'h00);
        check("sim_count_hold", 32'(io_count), 32'd2);
        check_write("sim_b", b);
        step(1'b0, none, 1'b0, 6'h00);
        check("sim_count_hold2", 32'(io_count), 32'd2);
        check_write("sim_c", c);
        step(1'b0, none, 1'b0, 6'h00);
        check("sim_count_1", 32'(io_count), 32'd1);
        check_write("sim_d", d);
        step(1'b0, none, 1'b0, 6'h00);
        check("sim_empty", 32'(io_count), 32'd0);

        // Read hazard
        step(1'b1, h1, 1'b1, 6'h13);
        check("hz_enq_nomatch", 32'(io_read_hazard), 32'd0);
        step(1'b0, none, 1'b1, 6'h12);
        check("hz_pending_match", 32'(io_read_hazard), 32'(c_HZ));
        io_read_idx = 6'h13;
        #1;
        check("hz_pending_nomatch", 32'(io_read_hazard), 32'd0);
        step(1'b1, h2, 1'b1, 6'h20);
        check("hz_enq_match", 32'(io_read_hazard), 32'(c_HZ));
        step(1'b0, none, 1'b0, 6'h12);
        check("hz_no_read", 32'(io_read_hazard), 32'd0);
        check_write("hz_drain_h1", h1);

        // Reset mid-drain with count=3
        step(1'b1, h3, 1'b1, 6'h3F);
        step(1'b1, h4, 1'b1, 6'h3F);
        step(1'b0, none, 1'b1, 6'h3F);
        check("mid_count3", 32'(io_count), 32'd3);
        @(negedge clock);
        reset = 1'b1;
        io_read_valid = 1'b0;
        #1;
        check("mid_no_write_in_reset", 32'(io_write_en), 32'd0);
        step(1'b0, none, 1'b0, 6'h00);
        check("mid_count",    32'(io_count),    32'd0);
        check("mid_write_en", 32'(io_write_en), 32'd0);
        check("mid_ready",    32'(io_in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, none, 1'b0, 6'h00);
            check("mid_no_stale", 32'(io_write_en), 32'd0);
        end
        step(1'b0, none, 1'b1, 6'h30);
        check("hz_stale_slot", 32'(io_read_hazard), 32'd0);
        step(1'b1, f, 1'b0, 6'h00);
        step(1'b0, none, 1'b0, 6'h00);
        check_write("post_reset", f);
        step(1'b0, none, 1'b0, 6'h00);
        check("post_reset_empty", 32'(io_count),    32'd0);
        check("post_reset_idle",  32'(io_write_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dcache_meta_write_buffer
`default_nettype wire

// File: doc/dcache_meta_write_buffer.md
DCACHE_META_WRITE_BUFFER -- requirements
Module: dcache_meta_write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered metadata writes (power of two, 2..8).
REQ-002 The block SHALL have parameter IDX_W, default 6, meaning the set-index width.
REQ-003 The block SHALL have parameter WAY_W, default 8, meaning the one-hot way-enable width.
REQ-004 The block SHALL have parameter TAG_W, default 20, meaning the tag width.
REQ-005 The block SHALL have the port clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have the port reset  input  1  meaning a synchronous, active-high reset.
REQ-007 The block SHALL have the ports io_in_valid / io_in_ready  input / output  1 / 1  meaning the enqueue handshake from the upstream metadata-write arbiter.
REQ-008 The block SHALL have the ports io_in_bits_idx / io_in_bits_way_en / io_in_bits_tag  input  IDX_W / WAY_W / TAG_W  meaning the enqueue payload.
REQ-009 The block SHALL have the ports io_read_valid / io_read_idx  input  1 / IDX_W  meaning a tag-array read this cycle.
REQ-010 The block SHALL have the port io_read_hazard  output  1  meaning the read set has a pending or in-flight write.
REQ-011 The block SHALL have the ports io_write_en / io_write_idx / io_write_way_en / io_write_tag  output  1 / IDX_W / WAY_W / TAG_W  meaning the tag-array write strobe and payload.
REQ-012 The block SHALL have the port io_count  output  $clog2(DEPTH)+1  meaning the current occupancy.

Function
REQ-013 The block SHALL hold the queue in a circular buffer of DEPTH entries with head and tail pointers and a count.
REQ-014 io_in_ready SHALL equal (count != DEPTH), with no same-cycle pass-through when full.
REQ-015 An enqueue SHALL occur when io_in_valid & io_in_ready, writing the entry at the tail and advancing the tail modulo DEPTH.
REQ-016 The block SHALL have a two-state FSM: IDLE while empty; DRAIN while count != 0.
REQ-017 io_write_en SHALL equal (state == DRAIN) & ~io_read_valid, so reads take priority and a read stalls the drain.
REQ-018 When io_write_en=1, io_write_idx, io_write_way_en and io_write_tag SHALL present the head entry combinationally, and the head SHALL advance modulo DEPTH on that edge.
REQ-019 When io_write_en=0, the payload outputs SHALL be zero.
REQ-020 Latency SHALL be: an entry enqueued at edge N into an empty buffer is written no earlier than the cycle after N (minimum 1 cycle), with no combinational in-to-write path.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged, and entries SHALL drain in strict FIFO order.
REQ-022 Transitions SHALL be: IDLE->DRAIN on enqueue; DRAIN->IDLE when the last entry dequeues with no same-cycle enqueue.
REQ-023 io_count SHALL reflect the registered count; count arithmetic SHALL never wrap, because overflow and underflow are impossible by the handshake.

Reset
REQ-024 On reset, the head, tail and count SHALL be set to 0 and the FSM to IDLE.
REQ-025 After reset, io_write_en, io_read_hazard and io_count SHALL be 0, and io_in_ready SHALL be 1.
REQ-026 Reset mid-drain SHALL discard all entries, with no write issued in the reset cycle; entry storage need not be cleared.

Configuration
REQ-027 With META_WRITE_BUF_HAZARD_EN defined, io_read_hazard SHALL be io_read_valid & (io_read_idx matches the idx of any occupied entry, or the accepted enqueue idx this cycle).
REQ-028 Without META_WRITE_BUF_HAZARD_EN, io_read_hazard SHALL be tied to 0, no comparators SHALL be synthesized, and all other behaviour SHALL be identical.

Structure
REQ-029 Package dcache_meta_wb_pkg SHALL hold the default width constants and the typedef meta_wb_entry_t {idx, way_en, tag}.
REQ-030 The block SHALL have one sub-module, meta_wb_hazard_cmp (DEPTH-way idx match against the occupancy mask), instantiated only under META_WRITE_BUF_HAZARD_EN.

Verification
REQ-031 After reset, enqueue idx=5, way=0x04, tag=0xABCDE with io_read_valid=0 -> write_en=1 exactly one cycle later with the same payload, then count=0 and state IDLE.
REQ-032 Enqueue 4 entries back-to-back with io_read_valid=1 held -> count=4, io_in_ready=0, and no writes; release the read -> 4 writes in enqueue order on consecutive cycles.
REQ-033 With count=2, assert enqueue and drain in the same cycle -> count stays 2, and FIFO order is preserved through a pointer wrap (tail 3->0).
REQ-034 With the macro defined, pending idx=0x12 and read idx=0x12 -> hazard=1; read idx=0x13 -> hazard=0; read idx equal to a same-cycle enqueue idx -> hazard=1; with the macro undefined -> hazard stays 0.
REQ-035 Assert reset with count=3 mid-drain -> the next cycle shows count=0, write_en=0 and io_in_ready=1, and no stale entry is ever written.
